// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_pkg
// Brief    : Shared index helpers for the round-robin handshake arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arbiter_pkg;

    // Width of an index into n sources; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_pick
// Brief    : Round-robin winner search starting at prio_ptr, with wrap.
// Revision : 1.0 - initial release
// ============================================================================
import rr_arbiter_pkg::*;

module rr_grant_pick #(
    parameter  int REQ_NUM = 8,
    localparam int IDX_W   = idx_w(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   prio_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [REQ_NUM-1:0]   w_mask;
    logic [2*REQ_NUM-1:0] w_dbl;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_mask[i] = (i >= int'(prio_ptr));
        end
    end

    // Lower half keeps only requests at or above the pointer; upper half is the wrap.
    assign w_dbl = {req, req & w_mask};

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < 2*REQ_NUM; i++) begin
            if (!found && w_dbl[i]) begin
                found  = 1'b1;
                winner = IDX_W'(i % REQ_NUM);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/round_robin_arbiter_handshake.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_arbiter_handshake
// Brief    : Packet-level N:1 round-robin arbiter with valid/ready/last.
//            RRARB_OUTPUT_REG_EN adds a 2-entry registered skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
import rr_arbiter_pkg::*;

module round_robin_arbiter_handshake #(
    parameter int REQ_NUM    = 8,
    parameter int DATA_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            valid_in,
    output logic [REQ_NUM-1:0]            ready_in,
    input  logic [REQ_NUM-1:0]            last_in,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] data_in,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic                          last_out,
    output logic [DATA_WIDTH-1:0]         data_out
);

    localparam int IDX_W = idx_w(REQ_NUM);

    logic [IDX_W-1:0]      r_prio_ptr;
    logic                  r_locked;
    logic [IDX_W-1:0]      r_gnt_idx;

    logic                  w_pick_found;
    logic [IDX_W-1:0]      w_pick_idx;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_active;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_up_valid;
    logic                  w_up_last;
    logic                  w_up_ready;
    logic                  w_up_fire;

    rr_grant_pick #(
        .REQ_NUM (REQ_NUM)
    ) u_pick (
        .req      (valid_in),
        .prio_ptr (r_prio_ptr),
        .found    (w_pick_found),
        .winner   (w_pick_idx)
    );

    assign w_sel    = r_locked ? r_gnt_idx : w_pick_idx;
    // Reset forces the upstream side quiet even while sources keep requesting.
    assign w_active = (r_locked | w_pick_found) & ~rst;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_up_valid = w_active & valid_in[w_sel];
    assign w_up_last  = w_active & last_in[w_sel];
    assign w_up_fire  = w_up_valid & w_up_ready;

    always_comb begin
        ready_in = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            ready_in[i] = w_up_ready & w_active & (w_sel == IDX_W'(i));
        end
    end

    // Grant is held through stalls and mid-packet beats; released on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_ptr <= '0;
            r_locked   <= 1'b0;
            r_gnt_idx  <= '0;
        end else if (w_up_fire && w_up_last) begin
            r_locked   <= 1'b0;
            r_prio_ptr <= IDX_W'(next_idx(int'(w_sel), REQ_NUM));
        end else if (w_up_valid) begin
            r_locked   <= 1'b1;
            r_gnt_idx  <= w_sel;
        end
    end

`ifdef RRARB_OUTPUT_REG_EN
    logic [1:0]            r_cnt;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_last;
    logic                  w_pop;

    assign w_up_ready = (r_cnt != 2'd2);
    assign w_pop      = valid_out & ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_buf_last <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
            end
        end else begin
            if (w_up_fire) begin
                r_buf_data[r_wr_ptr] <= w_sel_data;
                r_buf_last[r_wr_ptr] <= w_up_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_up_fire} - {1'b0, w_pop};
        end
    end

    assign valid_out = (r_cnt != 2'd0);
    assign last_out  = valid_out & r_buf_last[r_rd_ptr];
    assign data_out  = valid_out ? r_buf_data[r_rd_ptr] : '0;
`else
    assign w_up_ready = ready_out;
    assign valid_out  = w_up_valid;
    assign last_out   = w_up_last;
    assign data_out   = w_active ? w_sel_data : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter_handshake.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_robin_arbiter_handshake
// Brief    : Scoreboard bench for the round-robin handshake arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter_handshake;

    localparam int N  = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_in;
    logic [N-1:0]    last_in;
    logic [N*DW-1:0] data_in;
    logic            valid_out;
    logic            ready_out;
    logic            last_out;
    logic [DW-1:0]   data_out;

    always #5 clk = ~clk;

    round_robin_arbiter_handshake #(
        .REQ_NUM    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .last_in   (last_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_out  (last_out),
        .data_out  (data_out)
    );

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic          rdy_q[$];
    logic [DW-1:0] bq_data [N][16];
    logic          bq_last [N][16];
    int            hd [N];
    int            tl [N];
    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] next_byte = 8'h11;
    logic [DW-1:0] s5_first;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Queue one packet on source s and record its beats as the next expected output.
    task automatic pkt(input int s, input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            bq_data[s][tl[s]] = next_byte;
            bq_last[s][tl[s]] = (b == n - 1);
            e.src  = s;
            e.data = next_byte;
            e.last = (b == n - 1);
            sb.push_back(e);
            tl[s]++;
            next_byte++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hd[i] < tl[i]) begin
                valid_in[i]          = 1'b1;
                last_in[i]           = bq_last[i][hd[i]];
                data_in[i*DW +: DW]  = bq_data[i][hd[i]];
            end else begin
                valid_in[i]          = 1'b0;
                last_in[i]           = 1'b0;
                data_in[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic monitor();
        exp_t     e;
        logic [N-1:0] exp_rdy;
        chk("ready_onehot0", 32'($onehot0(ready_in)), 32'd1);
        if (valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(valid_out), 32'd0);
            end else begin
                e       = sb[0];
                exp_rdy = '0;
                if (ready_out) exp_rdy[e.src] = 1'b1;
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("last_out", 32'(last_out), 32'(e.last));
                chk("ready_in", 32'(ready_in), 32'(exp_rdy));
                if (ready_out) void'(sb.pop_front());
            end
        end else begin
            chk("idle_outputs", 32'({last_out, data_out, ready_in}), 32'd0);
        end
    endtask

    task automatic step();
        logic [N-1:0] fired;
        @(negedge clk);
        monitor();
        fired = ready_in & valid_in;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i]) hd[i]++;
        end
        drive();
        ready_out = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        rst       = 1'b1;
        valid_in  = '0;
        last_in   = '0;
        data_in   = '0;
        ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        valid_in = '1;
        last_in  = '1;
        data_in  = {N{8'hA5}};
        @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_in",  32'(ready_in),  32'd0);
        chk("rst_last_out",  32'(last_out),  32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        valid_in = '0;
        last_in  = '0;
        data_in  = '0;
        rst      = 1'b0;
        step();
        step();

        // All sources, single-beat packets: rotation 0..7 twice.
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) pkt(s, 1);
        end
        drive();
        drain();

        // Source 3 four-beat packet under backpressure, source 5 waiting.
        pkt(3, 4);
        pkt(5, 1);
        rdy_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ready_out = 1'b1;
        drive();
        drain();

        // Pointer moves to 7 after source 6; then 7 and 0 wrap.
        pkt(6, 1);
        drive();
        drain();
        pkt(7, 1);
        pkt(0, 1);
        drive();
        drain();

        // Stalled grant on source 2 survives a higher-priority newcomer.
        s5_first = next_byte;
        pkt(2, 2);
        ready_out = 1'b0;
        rdy_q = '{1'b0, 1'b0};
        drive();
        #1;
        chk("s5_valid_out", 32'(valid_out), 32'd1);
        chk("s5_ready_in",  32'(ready_in),  32'd0);
        step();
        step();
        pkt(1, 1);
        drive();
        #1;
        chk("s5_hold_data", 32'(data_out),    32'(s5_first));
        chk("s5_hold_rdy1", 32'(ready_in[1]), 32'd0);
        drain();

        // Reset in the middle of a source-4 packet.
        pkt(4, 3);
        drive();
        n = 0;
        while (sb.size() > 2 && n < 50) begin
            step();
            n++;
        end
        chk("s6_first_beat", 32'(sb.size()), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_valid_out", 32'(valid_out), 32'd0);
        chk("s6_rst_ready_in",  32'(ready_in),  32'd0);
        chk("s6_rst_last_out",  32'(last_out),  32'd0);
        chk("s6_rst_data_out",  32'(data_out),  32'd0);
        sb.delete();
        for (int i = 0; i < N; i++) hd[i] = tl[i];
        drive();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pkt(0, 1);
        pkt(5, 1);
        drive();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
